// File: rtl/bias_sram_reader_pkg.sv
// Shared types and constants for the bias SRAM reader and its SRAM port.
package bias_rd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } bias_rd_state_t;

  localparam int BIAS_ADDR_W     = 9;
  localparam int BIAS_DATA_W     = 32;
  localparam int BIAS_DEPTH      = 384;
  localparam int BIAS_FIFO_DEPTH = 2;

endpackage

// File: rtl/bias_sram_reader_if.sv
// Single-port SRAM bus. W_req is an active-low write enable (WEB style);
// R_data is valid the cycle after a cs/oe read cycle.
interface sp_ram_intf
  import bias_rd_pkg::*;
#(
  parameter int ADDR_W = BIAS_ADDR_W,
  parameter int DATA_W = BIAS_DATA_W
);

  logic              cs;
  logic              oe;
  logic [ADDR_W-1:0] addr;
  logic              W_req;
  logic [DATA_W-1:0] W_data;
  logic [DATA_W-1:0] R_data;

  modport compute (
    output cs, oe, addr, W_req, W_data,
    input  R_data
  );

  modport memory (
    input  cs, oe, addr, W_req, W_data,
    output R_data
  );

endinterface

// File: rtl/bias_sram_reader_fifo.sv
// Small synchronous FIFO that absorbs the SRAM read latency. Pops on an
// empty FIFO and pushes on a full FIFO without a same-cycle pop are ignored.
module bias_rd_fifo
  import bias_rd_pkg::*;
#(
  parameter int FIFO_DEPTH = BIAS_FIFO_DEPTH,
  parameter int DATA_W     = BIAS_DATA_W,
  localparam int CNT_W     = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  localparam logic [CNT_W-1:0] FULL     = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);

  logic [DATA_W-1:0] store_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wrPtr_q;
  logic [PTR_W-1:0]  rdPtr_q;
  logic [CNT_W-1:0]  count_q;
  logic              doPush;
  logic              doPop;

  assign doPop  = pop && (count_q != '0);
  assign doPush = push && ((count_q != FULL) || doPop);
  assign head   = store_q[rdPtr_q];
  assign empty  = (count_q == '0);
  assign count  = count_q;

  // Storage, ring pointers and occupancy; a simultaneous push and pop keeps
  // the count and preserves ordering because the pointers move independently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        store_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) begin
        store_q[wrPtr_q] <= push_data;
        wrPtr_q <= (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
      end
      if (doPop) begin
        rdPtr_q <= (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
      end
      case ({doPush, doPop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/bias_sram_reader.sv
// Reads a range of bias words from the bias SRAM and streams them out on a
// valid/ready interface. Reads are credit-gated against the output FIFO so
// a word returning from the SRAM always has a slot to land in.
module bias_sram_reader
  import bias_rd_pkg::*;
#(
  parameter int ADDR_W     = BIAS_ADDR_W,
  parameter int DATA_W     = BIAS_DATA_W,
  parameter int DEPTH      = BIAS_DEPTH,
  parameter int FIFO_DEPTH = BIAS_FIFO_DEPTH
)(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_cnt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] bias_data,
  output logic              bias_valid,
  input  logic              bias_ready,
  sp_ram_intf.compute       mem
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W:0]    FIFO_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_LIM  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE   = ADDR_W'(1);

  bias_rd_state_t    state_q;
  logic [ADDR_W-1:0] nextAddr_q;
  logic [ADDR_W-1:0] lastAddr_q;
  logic [ADDR_W-1:0] remaining_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  logic [CNT_W-1:0]  fifoCount;
  logic              fifoEmpty;
  logic              pop;
  logic              issue;
  logic              drainDone;
  logic [CNT_W:0]    occupancy;
  logic [ADDR_W:0]   endAddr;

  assign bias_valid = ~fifoEmpty;
  assign pop        = bias_valid & bias_ready;
  assign occupancy  = {1'b0, fifoCount} + {{CNT_W{1'b0}}, inflight_q}
                    - {{CNT_W{1'b0}}, pop};
  assign issue      = (state_q == FETCH) && (remaining_q != '0)
                    && (occupancy < FIFO_LIMIT);
  assign drainDone  = (state_q == DRAIN) && !inflight_q && (occupancy == '0);
  assign endAddr    = {1'b0, base_addr} + {1'b0, word_cnt};

  assign mem.cs     = issue;
  assign mem.oe     = issue;
  assign mem.addr   = issue ? nextAddr_q : lastAddr_q;
  assign mem.W_req  = 1'b1;
  assign mem.W_data = '0;

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;

  bias_rd_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .DATA_W     (DATA_W)
  ) uFifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight_q),
    .push_data (mem.R_data),
    .pop       (pop),
    .head      (bias_data),
    .empty     (fifoEmpty),
    .count     (fifoCount)
  );

  // Command acceptance, read sequencing and completion, all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      nextAddr_q  <= '0;
      lastAddr_q  <= '0;
      remaining_q <= '0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      inflight_q <= issue;
      if (issue) begin
        lastAddr_q  <= nextAddr_q;
        nextAddr_q  <= nextAddr_q + ADDR_ONE;
        remaining_q <= remaining_q - ADDR_ONE;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            if (word_cnt == '0) begin
              done_q <= 1'b1;
            end else if (endAddr > DEPTH_LIM) begin
              err_q <= 1'b1;
            end else begin
              nextAddr_q  <= base_addr;
              remaining_q <= word_cnt;
              busy_q      <= 1'b1;
              state_q     <= FETCH;
            end
          end
        end
        FETCH: begin
          if (issue && (remaining_q == ADDR_ONE)) begin
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (drainDone) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_sram_reader.sv
// Directed bench for bias_sram_reader with a behavioural SRAM and a
// scoreboard queue of expected bias words.
module tb_bias_sram_reader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [8:0]  base_addr;
  logic [8:0]  word_cnt;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] bias_data;
  logic        bias_valid;
  logic        bias_ready;

  int checks;
  int errors;
  int doneCount;
  int errCount;
  int csCount;
  int pending;
  logic [8:0]  lastCsAddr;
  logic [31:0] sram [512];
  logic [31:0] expQ [$];

  sp_ram_intf #(.ADDR_W(9), .DATA_W(32)) memIf ();

  bias_sram_reader dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .word_cnt   (word_cnt),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .bias_data  (bias_data),
    .bias_valid (bias_valid),
    .bias_ready (bias_ready),
    .mem        (memIf)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural SRAM with one cycle of read latency.
  always @(posedge clk) begin
    if (memIf.cs && memIf.oe) begin
      memIf.R_data <= sram[memIf.addr];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Passive monitor: scoreboard pops, SRAM-cycle bookkeeping and pulse counts.
  always @(negedge clk) begin
    logic popNow;
    logic [31:0] expWord;
    if (rst) begin
      pending = 0;
    end else begin
      popNow = bias_valid && bias_ready;
      if (memIf.cs) begin
        csCount++;
        lastCsAddr = memIf.addr;
        checkOutput("oe_with_cs", memIf.oe, 1);
        checkOutput("w_req_high", memIf.W_req, 1);
      end
      if (popNow) begin
        checks++;
        assert (expQ.size() != 0) else begin
          errors++;
          $error("[TB] FAIL unexpected_word: observed=0x%0h expected=none", bias_data);
        end
        if (expQ.size() != 0) begin
          expWord = expQ.pop_front();
          checkOutput("bias_data", bias_data, expWord);
        end
      end
      pending = pending + (memIf.cs ? 1 : 0) - (popNow ? 1 : 0);
      if (memIf.cs) begin
        checkOutput("credit_limit", (pending <= 2) ? 1 : 0, 1);
      end
      if (done) doneCount++;
      if (err) errCount++;
    end
  end

  task automatic applyStimulus(input logic [8:0] base, input logic [8:0] cnt);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = base;
    word_cnt  = cnt;
    if (cnt != 0 && (int'(base) + int'(cnt)) <= 384) begin
      for (int i = 0; i < int'(cnt); i++) begin
        expQ.push_back(sram[int'(base) + i]);
      end
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int d0;
    logic seen;
    d0 = doneCount;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (doneCount != d0) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, seen, 1);
  endtask

  initial begin
    int d0;
    int e0;
    int c0;
    checks     = 0;
    errors     = 0;
    doneCount  = 0;
    errCount   = 0;
    csCount    = 0;
    pending    = 0;
    lastCsAddr = '0;
    rst        = 1'b1;
    start      = 1'b0;
    base_addr  = '0;
    word_cnt   = '0;
    bias_ready = 1'b1;
    for (int i = 0; i < 512; i++) sram[i] = 32'hC0DE_0000 + i;
    for (int i = 0; i < 4; i++) sram[10 + i] = 32'hA0 + i;

    // Reset values
    #2;
    checkOutput("rst_cs", memIf.cs, 0);
    checkOutput("rst_oe", memIf.oe, 0);
    checkOutput("rst_addr", memIf.addr, 0);
    checkOutput("rst_w_req", memIf.W_req, 1);
    checkOutput("rst_w_data", memIf.W_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    checkOutput("rst_valid", bias_valid, 0);
    checkOutput("rst_data", bias_data, 0);
    #20 rst = 1'b0;
    repeat (2) @(posedge clk);

    // Basic read with cycle-exact timing
    $display("[TB] basic read base=10 cnt=4");
    c0 = csCount;
    applyStimulus(9'd10, 9'd4);
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      checkOutput($sformatf("basic_cs_c%0d", k), memIf.cs, (k <= 4) ? 1 : 0);
      checkOutput($sformatf("basic_valid_c%0d", k), bias_valid, (k >= 3 && k <= 6) ? 1 : 0);
      if (k >= 3 && k <= 6) begin
        checkOutput($sformatf("basic_data_c%0d", k), bias_data, 32'hA0 + (k - 3));
      end
      checkOutput($sformatf("basic_done_c%0d", k), done, (k == 7) ? 1 : 0);
      checkOutput($sformatf("basic_busy_c%0d", k), busy, (k <= 6) ? 1 : 0);
      checkOutput($sformatf("basic_w_req_c%0d", k), memIf.W_req, 1);
      if (k == 1) checkOutput("basic_first_addr", memIf.addr, 10);
    end
    @(posedge clk); #1;
    checkOutput("basic_cs_cycles", csCount - c0, 4);
    checkOutput("basic_queue_empty", expQ.size(), 0);

    // Backpressure with ready pattern 1,0,0 repeating
    $display("[TB] backpressure base=0 cnt=6");
    d0 = doneCount;
    c0 = csCount;
    applyStimulus(9'd0, 9'd6);
    for (int i = 0; i < 80 && doneCount == d0; i++) begin
      bias_ready = (i % 3 == 0);
      @(posedge clk); #1;
    end
    bias_ready = 1'b1;
    checkOutput("bp_done_seen", doneCount - d0, 1);
    checkOutput("bp_queue_empty", expQ.size(), 0);
    checkOutput("bp_cs_cycles", csCount - c0, 6);

    // Zero count
    $display("[TB] zero count");
    c0 = csCount;
    applyStimulus(9'd5, 9'd0);
    @(negedge clk);
    checkOutput("zero_done", done, 1);
    checkOutput("zero_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("zero_no_cs", csCount - c0, 0);

    // Range error, then the largest legal range
    $display("[TB] range error base=380 cnt=8");
    c0 = csCount;
    e0 = errCount;
    applyStimulus(9'd380, 9'd8);
    @(negedge clk);
    checkOutput("range_err_pulse", err, 1);
    checkOutput("range_busy", busy, 0);
    @(negedge clk);
    checkOutput("range_err_single", err, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("range_no_cs", csCount - c0, 0);
    checkOutput("range_err_count", errCount - e0, 1);

    $display("[TB] edge range base=376 cnt=8");
    e0 = errCount;
    applyStimulus(9'd376, 9'd8);
    waitDone("edge_done", 40);
    checkOutput("edge_last_addr", lastCsAddr, 383);
    checkOutput("edge_no_err", errCount - e0, 0);
    checkOutput("edge_queue_empty", expQ.size(), 0);

    // Start while busy is ignored
    $display("[TB] start while busy");
    d0 = doneCount;
    c0 = csCount;
    applyStimulus(9'd200, 9'd5);
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = 9'd100;
    word_cnt  = 9'd5;
    @(posedge clk); #1;
    start = 1'b0;
    waitDone("busy_done", 40);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("busy_single_done", doneCount - d0, 1);
    checkOutput("busy_cs_cycles", csCount - c0, 5);
    checkOutput("busy_queue_empty", expQ.size(), 0);

    // Reset in the middle of a transfer
    $display("[TB] reset mid-transfer");
    applyStimulus(9'd50, 9'd8);
    repeat (3) @(posedge clk);
    #1;
    d0 = doneCount;
    rst = 1'b1;
    #1;
    checkOutput("midrst_cs", memIf.cs, 0);
    checkOutput("midrst_valid", bias_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", doneCount - d0, 0);
    applyStimulus(9'd60, 9'd3);
    waitDone("after_rst_done", 40);
    checkOutput("after_rst_queue_empty", expQ.size(), 0);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
